// File: rtl/mul_pkg.sv
// Shared definitions for the execute-stage multiplier and its scoreboard.
package mul_pkg;

   localparam int unsigned MUL_LAT = 3;

   typedef enum logic {
      MUL_UNSIGNED = 1'b0,
      MUL_SIGNED   = 1'b1
   } mul_mode_e;

endpackage

// File: rtl/mul_abs.sv
// Magnitude and sign extraction for one multiplier operand.
module mul_abs
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic             mode,
   output logic [WIDTH-1:0] abs_val,
   output logic             neg
);

   // The most-negative input maps to 2^(WIDTH-1), which still fits unsigned.
   assign neg     = (mode == MUL_SIGNED) && value[WIDTH-1];
   assign abs_val = neg ? ((~value) + WIDTH'(1)) : value;

endmodule

// File: rtl/mul_pipe.sv
// Three-stage pipelined signed/unsigned multiplier with valid/ready flow control and flush.
module mul_pipe
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               sign,
   input  logic [TAG_W-1:0]   in_tag,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int unsigned H = WIDTH / 2;

   logic stall;
   logic accept;
   logic v1, v2, v3;

   logic [WIDTH-1:0] abs_a_c, abs_b_c;
   logic             neg_a_c, neg_b_c;

   logic [WIDTH-1:0] abs_a1, abs_b1;
   logic             neg1;
   logic [TAG_W-1:0] tag1;

   logic [H-1:0]     a_hi, a_lo, b_hi, b_lo;
   logic [WIDTH-1:0] pp_hh, pp_hl, pp_lh, pp_ll;
   logic             neg2;
   logic [TAG_W-1:0] tag2;

   logic [WIDTH:0]     mid_c;
   logic [2*WIDTH-1:0] abs_p_c;
   logic [2*WIDTH-1:0] prod_c;

   assign stall     = v3 & ~out_ready;
   assign in_ready  = ~stall & ~flush;
   assign accept    = in_valid & in_ready;
   assign out_valid = v3;

   mul_abs #(.WIDTH(WIDTH)) u_abs_a (
      .value   (a),
      .mode    (sign),
      .abs_val (abs_a_c),
      .neg     (neg_a_c)
   );

   mul_abs #(.WIDTH(WIDTH)) u_abs_b (
      .value   (b),
      .mode    (sign),
      .abs_val (abs_b_c),
      .neg     (neg_b_c)
   );

   assign a_hi = abs_a1[WIDTH-1:H];
   assign a_lo = abs_a1[H-1:0];
   assign b_hi = abs_b1[WIDTH-1:H];
   assign b_lo = abs_b1[H-1:0];

   // Cross terms summed one bit wider so their carry reaches the upper half.
   always_comb begin
      mid_c   = {1'b0, pp_hl} + {1'b0, pp_lh};
      abs_p_c = {pp_hh, pp_ll} + {{(H-1){1'b0}}, mid_c, {H{1'b0}}};
      prod_c  = neg2 ? ((~abs_p_c) + (2*WIDTH)'(1)) : abs_p_c;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1     <= 1'b0;
         v2     <= 1'b0;
         v3     <= 1'b0;
         abs_a1 <= '0;
         abs_b1 <= '0;
         neg1   <= 1'b0;
         tag1   <= '0;
         pp_hh  <= '0;
         pp_hl  <= '0;
         pp_lh  <= '0;
         pp_ll  <= '0;
         neg2   <= 1'b0;
         tag2   <= '0;
         result <= '0;
         out_tag <= '0;
      end else begin
         if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
         end else if (!stall) begin
            v1 <= accept;
            v2 <= v1;
            v3 <= v2;
         end
         // Data moves with the pipe; an invalid stage may carry junk.
         if (!stall) begin
            abs_a1  <= abs_a_c;
            abs_b1  <= abs_b_c;
            neg1    <= neg_a_c ^ neg_b_c;
            tag1    <= in_tag;
            pp_hh   <= WIDTH'(a_hi) * WIDTH'(b_hi);
            pp_hl   <= WIDTH'(a_hi) * WIDTH'(b_lo);
            pp_lh   <= WIDTH'(a_lo) * WIDTH'(b_hi);
            pp_ll   <= WIDTH'(a_lo) * WIDTH'(b_lo);
            neg2    <= neg1;
            tag2    <= tag1;
            result  <= prod_c;
            out_tag <= tag2;
         end
      end
   end

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe at WIDTH=32 and WIDTH=8.
module tb_mul_pipe;
   import mul_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   logic        in_valid, in_ready, sign, flush, out_valid, out_ready;
   logic [31:0] a, b;
   logic [4:0]  in_tag, out_tag;
   logic [63:0] result;

   logic        e8_in_valid, e8_in_ready, e8_sign, e8_flush, e8_out_valid, e8_out_ready;
   logic [7:0]  e8_a, e8_b;
   logic [4:0]  e8_in_tag, e8_out_tag;
   logic [15:0] e8_result;

   mul_pipe #(.WIDTH(32), .TAG_W(5)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sign(sign), .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag)
   );

   mul_pipe #(.WIDTH(8), .TAG_W(5)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(e8_in_valid), .in_ready(e8_in_ready),
      .a(e8_a), .b(e8_b), .sign(e8_sign), .in_tag(e8_in_tag), .flush(e8_flush),
      .out_valid(e8_out_valid), .out_ready(e8_out_ready), .result(e8_result), .out_tag(e8_out_tag)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int pops32 = 0;

   typedef struct { logic [63:0] res; logic [4:0] tag; } exp32_t;
   typedef struct { logic [15:0] res; logic [4:0] tag; } exp8_t;
   exp32_t q32[$];
   exp8_t  q8[$];

   function automatic logic [63:0] model32(logic [31:0] x, logic [31:0] y, logic s);
      logic [63:0] xe, ye;
      xe = s ? {{32{x[31]}}, x} : {32'b0, x};
      ye = s ? {{32{y[31]}}, y} : {32'b0, y};
      return xe * ye;
   endfunction

   function automatic logic [15:0] model8(logic [7:0] x, logic [7:0] y, logic s);
      logic [15:0] xe, ye;
      xe = s ? {{8{x[7]}}, x} : {8'b0, x};
      ye = s ? {{8{y[7]}}, y} : {8'b0, y};
      return xe * ye;
   endfunction

   // Scoreboard: push on modelled accept, pop on output handshake.
   always @(negedge clk) begin
      exp32_t e;
      if (!rst_n) begin
         q32.delete();
      end else begin
         if (out_valid && out_ready) begin
            checks++;
            pops32++;
            if (q32.size() == 0) begin
               failures++;
               $display("FAIL sb32_spurious: got result=%h tag=%0d, required no output", result, out_tag);
            end else begin
               e = q32.pop_front();
               if (result !== e.res || out_tag !== e.tag) begin
                  failures++;
                  $display("FAIL sb32_data: got result=%h tag=%0d, required result=%h tag=%0d",
                           result, out_tag, e.res, e.tag);
               end
            end
         end
         if (flush) q32.delete();
         else if (in_valid && !(out_valid && !out_ready)) begin
            e.res = model32(a, b, sign);
            e.tag = in_tag;
            q32.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      exp8_t e;
      if (!rst_n) begin
         q8.delete();
      end else begin
         if (e8_out_valid && e8_out_ready) begin
            checks++;
            if (q8.size() == 0) begin
               failures++;
               $display("FAIL sb8_spurious: got result=%h tag=%0d, required no output", e8_result, e8_out_tag);
            end else begin
               e = q8.pop_front();
               if (e8_result !== e.res || e8_out_tag !== e.tag) begin
                  failures++;
                  $display("FAIL sb8_data: got result=%h tag=%0d, required result=%h tag=%0d",
                           e8_result, e8_out_tag, e.res, e.tag);
               end
            end
         end
         if (e8_flush) q8.delete();
         else if (e8_in_valid && !(e8_out_valid && !e8_out_ready)) begin
            e.res = model8(e8_a, e8_b, e8_sign);
            e.tag = e8_in_tag;
            q8.push_back(e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      checks++;
      if (out_valid !== 1'b0 || result !== 64'h0 || out_tag !== 5'h0) begin
         failures++;
         $display("FAIL reset32: got valid=%b result=%h tag=%0d, required 0/0/0", out_valid, result, out_tag);
      end
      checks++;
      if (e8_out_valid !== 1'b0 || e8_result !== 16'h0 || e8_out_tag !== 5'h0) begin
         failures++;
         $display("FAIL reset8: got valid=%b result=%h tag=%0d, required 0/0/0", e8_out_valid, e8_result, e8_out_tag);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || e8_in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: got %b/%b, required 1/1", in_ready, e8_in_ready);
      end
      tick();
   endtask

   // Operation presented in cycle 0 must be visible in cycle MUL_LAT only.
   task automatic test_signed();
      logic [31:0] va[3], vb[3];
      logic [63:0] ve[3];
      va = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000};
      vb = '{32'h80000000, 32'h00000001, 32'hFFFFFFFF};
      ve = '{64'h4000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h0};
      for (int i = 0; i < 3; i++) begin
         for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = (cyc == 0);
            a = va[i]; b = vb[i]; sign = MUL_SIGNED; in_tag = 5'(i + 1);
            @(negedge clk);
            checks++;
            if (out_valid !== (cyc == MUL_LAT)) begin
               failures++;
               $display("FAIL signed_latency: vec %0d cyc %0d got valid=%b, required %b", i, cyc, out_valid, cyc == MUL_LAT);
            end
            if (cyc == MUL_LAT) begin
               checks++;
               if (result !== ve[i] || out_tag !== 5'(i + 1)) begin
                  failures++;
                  $display("FAIL signed_value: vec %0d got %h tag %0d, required %h tag %0d", i, result, out_tag, ve[i], i + 1);
               end
            end
            tick();
         end
      end
   endtask

   task automatic test_unsigned();
      logic [31:0] va[3], vb[3];
      logic [63:0] ve[3];
      va = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
      vb = '{32'hFFFFFFFF, 32'h00000001, 32'h00000002};
      ve = '{64'hFFFFFFFE00000001, 64'h00000000FFFFFFFF, 64'h0000000100000000};
      for (int i = 0; i < 3; i++) begin
         for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = (cyc == 0);
            a = va[i]; b = vb[i]; sign = MUL_UNSIGNED; in_tag = 5'(i + 8);
            @(negedge clk);
            checks++;
            if (out_valid !== (cyc == MUL_LAT)) begin
               failures++;
               $display("FAIL unsigned_latency: vec %0d cyc %0d got valid=%b, required %b", i, cyc, out_valid, cyc == MUL_LAT);
            end
            if (cyc == MUL_LAT) begin
               checks++;
               if (result !== ve[i] || out_tag !== 5'(i + 8)) begin
                  failures++;
                  $display("FAIL unsigned_value: vec %0d got %h tag %0d, required %h tag %0d", i, result, out_tag, ve[i], i + 8);
               end
            end
            tick();
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int cyc = 0; cyc < 8; cyc++) begin
         in_valid = (cyc < 4);
         a = $urandom; b = $urandom; sign = 1'(cyc % 2); in_tag = 5'(cyc + 1);
         @(negedge clk);
         if (cyc < 4) begin
            checks++;
            if (in_ready !== 1'b1) begin
               failures++;
               $display("FAIL b2b_in_ready: cyc %0d got %b, required 1", cyc, in_ready);
            end
         end
         checks++;
         if (out_valid !== (cyc >= 3 && cyc <= 6)) begin
            failures++;
            $display("FAIL b2b_valid: cyc %0d got %b, required %b", cyc, out_valid, cyc >= 3 && cyc <= 6);
         end else if (out_valid && out_tag !== 5'(cyc - 2)) begin
            failures++;
            $display("FAIL b2b_tag: cyc %0d got %0d, required %0d", cyc, out_tag, cyc - 2);
         end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      int          next = 0;
      int          pops_start = pops32;
      logic [31:0] ca = $urandom, cb = $urandom;
      logic [63:0] held_res = '0;
      logic [4:0]  held_tag = '0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         out_ready = !(cyc >= 4 && cyc < 9);
         in_valid = (next < 8);
         a = ca; b = cb; sign = 1'(next % 2); in_tag = 5'(10 + next);
         @(negedge clk);
         if (cyc >= 4 && cyc < 9) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
               failures++;
               $display("FAIL bp_stall: cyc %0d got valid=%b in_ready=%b, required 1/0", cyc, out_valid, in_ready);
            end
            if (cyc == 4) begin
               held_res = result;
               held_tag = out_tag;
            end else begin
               checks++;
               if (result !== held_res || out_tag !== held_tag) begin
                  failures++;
                  $display("FAIL bp_hold: cyc %0d got %h tag %0d, required %h tag %0d", cyc, result, out_tag, held_res, held_tag);
               end
            end
         end
         if (in_valid && in_ready) begin
            next++;
            ca = $urandom; cb = $urandom;
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (pops32 - pops_start != 8 || q32.size() != 0) begin
         failures++;
         $display("FAIL bp_drain: got %0d outputs, %0d pending, required 8 outputs, 0 pending",
                  pops32 - pops_start, q32.size());
      end
   endtask

   task automatic test_flush();
      for (int cyc = 0; cyc < 12; cyc++) begin
         in_valid = (cyc <= 3 || cyc == 8);
         flush = (cyc == 3);
         out_ready = 1'b1;
         a = $urandom; b = $urandom; sign = 1'(cyc % 2); in_tag = 5'(20 + cyc);
         @(negedge clk);
         if (cyc == 3) begin
            checks++;
            if (in_ready !== 1'b0) begin
               failures++;
               $display("FAIL flush_in_ready: got %b, required 0", in_ready);
            end
         end
         if (cyc >= 4 && cyc <= 7) begin
            checks++;
            if (out_valid !== 1'b0) begin
               failures++;
               $display("FAIL flush_squash: cyc %0d got valid=%b, required 0", cyc, out_valid);
            end
         end
         if (cyc == 11) begin
            checks++;
            if (out_valid !== 1'b1 || out_tag !== 5'd28) begin
               failures++;
               $display("FAIL flush_resume: got valid=%b tag=%0d, required 1 tag 28", out_valid, out_tag);
            end
         end
         tick();
      end
      for (int cyc = 0; cyc < 10; cyc++) begin
         in_valid = (cyc == 0);
         out_ready = (cyc >= 6);
         flush = (cyc == 5);
         a = $urandom; b = $urandom; sign = MUL_SIGNED; in_tag = 5'd25;
         @(negedge clk);
         if (cyc == 4) begin
            checks++;
            if (out_valid !== 1'b1) begin
               failures++;
               $display("FAIL flush_stall_pre: got valid=%b, required 1", out_valid);
            end
         end
         if (cyc >= 6) begin
            checks++;
            if (out_valid !== 1'b0) begin
               failures++;
               $display("FAIL flush_stall_drop: cyc %0d got valid=%b, required 0", cyc, out_valid);
            end
         end
         tick();
      end
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset_midop();
      for (int cyc = 0; cyc < 9; cyc++) begin
         in_valid = (cyc < 2);
         rst_n = (cyc != 2);
         a = $urandom | 32'h1; b = $urandom | 32'h1; sign = MUL_UNSIGNED; in_tag = 5'(30 + cyc);
         @(negedge clk);
         if (cyc == 3) begin
            checks++;
            if (result !== 64'h0 || out_tag !== 5'h0) begin
               failures++;
               $display("FAIL midreset_clear: got result=%h tag=%0d, required 0/0", result, out_tag);
            end
         end
         if (cyc >= 3) begin
            checks++;
            if (out_valid !== 1'b0) begin
               failures++;
               $display("FAIL midreset_lost: cyc %0d got valid=%b, required 0", cyc, out_valid);
            end
         end
         tick();
      end
      in_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_width8();
      logic [7:0]  va[4], vb[4];
      logic        vs[4];
      logic [15:0] ve[4];
      va = '{8'h80, 8'hFF, 8'h80, 8'hFF};
      vb = '{8'h7F, 8'hFF, 8'h80, 8'h01};
      vs = '{1'b1, 1'b0, 1'b1, 1'b1};
      ve = '{16'hC080, 16'hFE01, 16'h4000, 16'hFFFF};
      for (int cyc = 0; cyc < 8; cyc++) begin
         e8_in_valid = (cyc < 4);
         e8_a = va[cyc % 4]; e8_b = vb[cyc % 4]; e8_sign = vs[cyc % 4]; e8_in_tag = 5'(cyc);
         @(negedge clk);
         checks++;
         if (e8_out_valid !== (cyc >= 3 && cyc <= 6)) begin
            failures++;
            $display("FAIL w8_valid: cyc %0d got %b, required %b", cyc, e8_out_valid, cyc >= 3 && cyc <= 6);
         end else if (e8_out_valid && (e8_result !== ve[cyc - 3] || e8_out_tag !== 5'(cyc - 3))) begin
            failures++;
            $display("FAIL w8_value: cyc %0d got %h tag %0d, required %h tag %0d",
                     cyc, e8_result, e8_out_tag, ve[cyc - 3], cyc - 3);
         end
         tick();
      end
      e8_in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; sign = 1'b0; in_tag = '0; flush = 1'b0; out_ready = 1'b1;
      e8_in_valid = 1'b0; e8_a = '0; e8_b = '0; e8_sign = 1'b0; e8_in_tag = '0; e8_flush = 1'b0;
      e8_out_ready = 1'b1;
      test_reset();
      test_signed();
      test_unsigned();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_midop();
      test_width8();
      repeat (4) tick();
      checks++;
      if (q32.size() != 0 || q8.size() != 0) begin
         failures++;
         $display("FAIL sb_empty: got %0d/%0d pending, required 0/0", q32.size(), q8.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
